// File: rtl/dat_xfer_sched.sv
// rtl/dat_xfer_sched.sv - DAT transfer sequencer: issues a data transfer one block at a time
//
// Sits between the host register block and the DAT control/phys pair.
// Ports:
//   host_clk, rst           single clock, synchronous active-high reset
//   start_tf                one-cycle request to begin a transfer; tf_direction,
//                           multiple_blk, block_cnt, block_sz are captured with it
//   timeout_val             per-block timeout in cycles, 0 disables it
//   abort                   level, cancels the transfer in progress
//   tx_buf_empty/rx_buf_full  buffer readiness for write/read blocks
//   blk_done/blk_crc_err    block completion pulse and its CRC status
//   sdc_busy_L              card busy (low while programming after a write block)
//   blk_start/blk_dir/blk_len  per-block request to the DAT engine
//   blocks_left             remaining block count
//   wr_tf_active/rd_tf_active/cmd_inhibit_dat  PSR activity bits
//   tf_complete/data_err    one-cycle completion and error pulses
//   err_code                01 = CRC error, 10 = timeout, held until the next transfer
module dat_xfer_sched #(
    parameter int BLOCK_SZ_WIDTH  = 12,
    parameter int BLOCK_CNT_WIDTH = 16,
    parameter int TIMEOUT_WIDTH   = 16
) (
    input  logic                       host_clk,
    input  logic                       rst,
    input  logic                       start_tf,
    input  logic                       tf_direction,
    input  logic                       multiple_blk,
    input  logic [BLOCK_CNT_WIDTH-1:0] block_cnt,
    input  logic [BLOCK_SZ_WIDTH-1:0]  block_sz,
    input  logic [TIMEOUT_WIDTH-1:0]   timeout_val,
    input  logic                       abort,
    input  logic                       tx_buf_empty,
    input  logic                       rx_buf_full,
    input  logic                       blk_done,
    input  logic                       blk_crc_err,
    input  logic                       sdc_busy_L,
    output logic                       blk_start,
    output logic                       blk_dir,
    output logic [BLOCK_SZ_WIDTH-1:0]  blk_len,
    output logic [BLOCK_CNT_WIDTH-1:0] blocks_left,
    output logic                       wr_tf_active,
    output logic                       rd_tf_active,
    output logic                       cmd_inhibit_dat,
    output logic                       tf_complete,
    output logic                       data_err,
    output logic [1:0]                 err_code
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        WAIT_BUF,
        ISSUE,
        XFER,
        BUSY_WAIT,
        NEXT,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0]                 ERR_CRC = 2'b01;
    localparam logic [1:0]                 ERR_TMO = 2'b10;
    localparam logic [BLOCK_CNT_WIDTH-1:0] ONE_BLK = BLOCK_CNT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH:0]     ONE_TMO = (TIMEOUT_WIDTH + 1)'(1);

    state_t state, state_d;

    logic [TIMEOUT_WIDTH-1:0]   tmo_cnt, tmo_cnt_d;
    logic                       req_dir, req_dir_d;
    logic                       req_multi, req_multi_d;
    logic [BLOCK_CNT_WIDTH-1:0] req_cnt, req_cnt_d;
    logic [BLOCK_SZ_WIDTH-1:0]  req_sz, req_sz_d;

    logic                       blk_start_d;
    logic                       blk_dir_d;
    logic [BLOCK_SZ_WIDTH-1:0]  blk_len_d;
    logic [BLOCK_CNT_WIDTH-1:0] blocks_left_d;
    logic                       wr_tf_active_d;
    logic                       rd_tf_active_d;
    logic                       cmd_inhibit_dat_d;
    logic                       tf_complete_d;
    logic                       data_err_d;
    logic [1:0]                 err_code_d;

    // Compared one bit wider so the increment can never wrap past the limit.
    logic [TIMEOUT_WIDTH:0] cnt_inc;
    logic [TIMEOUT_WIDTH:0] tmo_limit;
    logic                   tmo_hit;
    logic                   buf_ready;

    assign cnt_inc   = {1'b0, tmo_cnt} + ONE_TMO;
    assign tmo_limit = {1'b0, timeout_val} - ONE_TMO;
    // Fires on the cycle the counter steps onto timeout_val-1, so data_err
    // lands exactly timeout_val cycles after blk_start.
    assign tmo_hit   = (timeout_val != '0) && (cnt_inc >= tmo_limit);
    assign buf_ready = blk_dir ? !rx_buf_full : !tx_buf_empty;

    always_ff @(posedge host_clk) begin
        if (rst) begin
            state           <= IDLE;
            tmo_cnt         <= '0;
            req_dir         <= 1'b0;
            req_multi       <= 1'b0;
            req_cnt         <= '0;
            req_sz          <= '0;
            blk_start       <= 1'b0;
            blk_dir         <= 1'b0;
            blk_len         <= '0;
            blocks_left     <= '0;
            wr_tf_active    <= 1'b0;
            rd_tf_active    <= 1'b0;
            cmd_inhibit_dat <= 1'b0;
            tf_complete     <= 1'b0;
            data_err        <= 1'b0;
            err_code        <= 2'b00;
        end else begin
            state           <= state_d;
            tmo_cnt         <= tmo_cnt_d;
            req_dir         <= req_dir_d;
            req_multi       <= req_multi_d;
            req_cnt         <= req_cnt_d;
            req_sz          <= req_sz_d;
            blk_start       <= blk_start_d;
            blk_dir         <= blk_dir_d;
            blk_len         <= blk_len_d;
            blocks_left     <= blocks_left_d;
            wr_tf_active    <= wr_tf_active_d;
            rd_tf_active    <= rd_tf_active_d;
            cmd_inhibit_dat <= cmd_inhibit_dat_d;
            tf_complete     <= tf_complete_d;
            data_err        <= data_err_d;
            err_code        <= err_code_d;
        end
    end

    always_comb begin
        state_d           = state;
        tmo_cnt_d         = tmo_cnt;
        req_dir_d         = req_dir;
        req_multi_d       = req_multi;
        req_cnt_d         = req_cnt;
        req_sz_d          = req_sz;
        blk_start_d       = 1'b0;
        blk_dir_d         = blk_dir;
        blk_len_d         = blk_len;
        blocks_left_d     = blocks_left;
        wr_tf_active_d    = wr_tf_active;
        rd_tf_active_d    = rd_tf_active;
        cmd_inhibit_dat_d = cmd_inhibit_dat;
        tf_complete_d     = 1'b0;
        data_err_d        = 1'b0;
        err_code_d        = err_code;

        if (state != IDLE && abort) begin
            // Silent cancel: no pulses, block count left as it was.
            state_d           = IDLE;
            wr_tf_active_d    = 1'b0;
            rd_tf_active_d    = 1'b0;
            cmd_inhibit_dat_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_tf) begin
                        // Capture the request now; the host may change the fields afterwards.
                        req_dir_d   = tf_direction;
                        req_multi_d = multiple_blk;
                        req_cnt_d   = block_cnt;
                        req_sz_d    = block_sz;
                        state_d     = LOAD;
                    end
                end
                LOAD: begin
                    blk_dir_d         = req_dir;
                    blk_len_d         = req_sz;
                    err_code_d        = 2'b00;
                    blocks_left_d     = req_multi ? req_cnt : ONE_BLK;
                    cmd_inhibit_dat_d = 1'b1;
                    rd_tf_active_d    = req_dir;
                    wr_tf_active_d    = !req_dir;
                    state_d           = (req_multi && req_cnt == '0) ? DONE : WAIT_BUF;
                end
                WAIT_BUF: begin
                    if (buf_ready) begin
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    blk_start_d = 1'b1;
                    tmo_cnt_d   = '0;
                    state_d     = XFER;
                end
                XFER: begin
                    tmo_cnt_d = cnt_inc[TIMEOUT_WIDTH-1:0];
                    if (blk_done) begin
                        if (blk_crc_err) begin
                            state_d    = ERROR;
                            err_code_d = ERR_CRC;
                        end else begin
                            state_d = blk_dir ? NEXT : BUSY_WAIT;
                        end
                    end else if (tmo_hit) begin
                        state_d    = ERROR;
                        err_code_d = ERR_TMO;
                    end
                end
                BUSY_WAIT: begin
                    // Timeout keeps counting from the XFER phase of the same block.
                    tmo_cnt_d = cnt_inc[TIMEOUT_WIDTH-1:0];
                    if (sdc_busy_L) begin
                        state_d = NEXT;
                    end else if (tmo_hit) begin
                        state_d    = ERROR;
                        err_code_d = ERR_TMO;
                    end
                end
                NEXT: begin
                    if (blocks_left != '0) begin
                        blocks_left_d = blocks_left - ONE_BLK;
                    end
                    state_d = (blocks_left <= ONE_BLK) ? DONE : WAIT_BUF;
                end
                DONE: begin
                    tf_complete_d     = 1'b1;
                    wr_tf_active_d    = 1'b0;
                    rd_tf_active_d    = 1'b0;
                    cmd_inhibit_dat_d = 1'b0;
                    state_d           = IDLE;
                end
                ERROR: begin
                    data_err_d        = 1'b1;
                    wr_tf_active_d    = 1'b0;
                    rd_tf_active_d    = 1'b0;
                    cmd_inhibit_dat_d = 1'b0;
                    state_d           = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dat_xfer_sched.sv
// tb/tb_dat_xfer_sched.sv - self-checking bench for dat_xfer_sched
module tb_dat_xfer_sched;

    localparam int BSW = 12;
    localparam int BCW = 16;
    localparam int TW  = 16;

    logic           host_clk     = 1'b0;
    logic           rst          = 1'b1;
    logic           start_tf     = 1'b0;
    logic           tf_direction = 1'b0;
    logic           multiple_blk = 1'b0;
    logic [BCW-1:0] block_cnt    = '0;
    logic [BSW-1:0] block_sz     = '0;
    logic [TW-1:0]  timeout_val  = '0;
    logic           abort        = 1'b0;
    logic           tx_buf_empty = 1'b0;
    logic           rx_buf_full  = 1'b0;
    logic           blk_done     = 1'b0;
    logic           blk_crc_err  = 1'b0;
    logic           sdc_busy_L   = 1'b1;

    logic           blk_start;
    logic           blk_dir;
    logic [BSW-1:0] blk_len;
    logic [BCW-1:0] blocks_left;
    logic           wr_tf_active;
    logic           rd_tf_active;
    logic           cmd_inhibit_dat;
    logic           tf_complete;
    logic           data_err;
    logic [1:0]     err_code;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int start_q[$];
    int tfc_q[$];
    int derr_q[$];

    dat_xfer_sched #(
        .BLOCK_SZ_WIDTH (BSW),
        .BLOCK_CNT_WIDTH(BCW),
        .TIMEOUT_WIDTH  (TW)
    ) dut (
        .host_clk       (host_clk),
        .rst            (rst),
        .start_tf       (start_tf),
        .tf_direction   (tf_direction),
        .multiple_blk   (multiple_blk),
        .block_cnt      (block_cnt),
        .block_sz       (block_sz),
        .timeout_val    (timeout_val),
        .abort          (abort),
        .tx_buf_empty   (tx_buf_empty),
        .rx_buf_full    (rx_buf_full),
        .blk_done       (blk_done),
        .blk_crc_err    (blk_crc_err),
        .sdc_busy_L     (sdc_busy_L),
        .blk_start      (blk_start),
        .blk_dir        (blk_dir),
        .blk_len        (blk_len),
        .blocks_left    (blocks_left),
        .wr_tf_active   (wr_tf_active),
        .rd_tf_active   (rd_tf_active),
        .cmd_inhibit_dat(cmd_inhibit_dat),
        .tf_complete    (tf_complete),
        .data_err       (data_err),
        .err_code       (err_code)
    );

    always #5 host_clk = ~host_clk;

    always @(posedge host_clk) cyc <= cyc + 1;

    // Pulse log: each entry is the edge number after which the pulse was visible.
    always @(negedge host_clk) begin
        if (blk_start)   start_q.push_back(cyc);
        if (tf_complete) tfc_q.push_back(cyc);
        if (data_err)    derr_q.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge host_clk);
        #1;
    endtask

    task automatic do_start(input logic dir, input logic multi, input int cnt, input int sz);
        tf_direction = dir;
        multiple_blk = multi;
        block_cnt    = BCW'(cnt);
        block_sz     = BSW'(sz);
        start_tf     = 1'b1;
        tick();
        start_tf     = 1'b0;
        tf_direction = ~dir;
        multiple_blk = ~multi;
        block_cnt    = BCW'($urandom);
        block_sz     = BSW'($urandom);
    endtask

    task automatic pulse_done(input logic crc);
        blk_done    = 1'b1;
        blk_crc_err = crc;
        tick();
        blk_done    = 1'b0;
        blk_crc_err = 1'b0;
    endtask

    task automatic wait_start(input int budget, output bit ok);
        int n = 0;
        while (!blk_start && n < budget) begin
            tick();
            n++;
        end
        ok = blk_start;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({blk_start, blk_dir, wr_tf_active, rd_tf_active, cmd_inhibit_dat, tf_complete, data_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {blk_start, blk_dir, wr_tf_active, rd_tf_active, cmd_inhibit_dat, tf_complete, data_err});
        end
        checks++;
        if (blk_len !== '0 || blocks_left !== '0) begin
            errors++;
            $display("FAIL reset_fields: got len %0d left %0d expected 0 0", blk_len, blocks_left);
        end
        checks++;
        if (err_code !== 2'b00) begin
            errors++;
            $display("FAIL reset_err_code: got %b expected 00", err_code);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        int n, sz, s0, t0;
        s0 = start_q.size();
        t0 = tfc_q.size();
        rx_buf_full = 1'b0;
        sz = $urandom_range(1, 4095);
        do_start(1'b1, 1'b0, $urandom_range(2, 100), sz);
        n = cyc;
        tick();
        checks++;
        if ({rd_tf_active, wr_tf_active, cmd_inhibit_dat} !== 3'b101) begin
            errors++;
            $display("FAIL rd_psr_n1: got %b expected 101", {rd_tf_active, wr_tf_active, cmd_inhibit_dat});
        end
        checks++;
        if (blocks_left !== BCW'(1)) begin
            errors++;
            $display("FAIL rd_single_left: got %0d expected 1", blocks_left);
        end
        tick();
        checks++;
        if (blk_start !== 1'b0) begin
            errors++;
            $display("FAIL rd_no_early_start: got %b expected 0 at cycle %0d", blk_start, cyc - n);
        end
        tick();
        checks++;
        if (blk_start !== 1'b1) begin
            errors++;
            $display("FAIL rd_start_n3: got %b expected 1 at cycle %0d", blk_start, cyc - n);
        end
        checks++;
        if (blk_dir !== 1'b1 || blk_len !== BSW'(sz)) begin
            errors++;
            $display("FAIL rd_latched: got dir %b len %0d expected 1 %0d", blk_dir, blk_len, sz);
        end
        repeat ($urandom_range(0, 5)) tick();
        pulse_done(1'b0);
        tick();
        checks++;
        if (blocks_left !== '0) begin
            errors++;
            $display("FAIL rd_left_zero: got %0d expected 0", blocks_left);
        end
        tick();
        checks++;
        if (tf_complete !== 1'b1 || {rd_tf_active, wr_tf_active, cmd_inhibit_dat} !== 3'b000) begin
            errors++;
            $display("FAIL rd_complete: got tfc %b psr %b expected 1 000",
                     tf_complete, {rd_tf_active, wr_tf_active, cmd_inhibit_dat});
        end
        tick();
        checks++;
        if (tfc_q.size() - t0 != 1 || start_q.size() - s0 != 1) begin
            errors++;
            $display("FAIL rd_pulse_counts: got tfc %0d starts %0d expected 1 1",
                     tfc_q.size() - t0, start_q.size() - s0);
        end
    endtask

    // Write transfer with card busy after every block and optional TX stalls.
    // Next blk_start = one cycle after the first buffer-ready sample, where
    // buffer sampling begins two cycles after busy release.
    task automatic test_multi_write(input int nblk, input bit fixed);
        int n, s0, t0, d, r, rdy, dd, bl, exp_next, exp_left, sz;
        bit ok;
        s0 = start_q.size();
        t0 = tfc_q.size();
        tx_buf_empty = 1'b0;
        sdc_busy_L   = 1'b1;
        timeout_val  = '0;
        sz = $urandom_range(1, 4095);
        r  = 0;
        do_start(1'b0, 1'b1, nblk, sz);
        n = cyc;
        tick();
        checks++;
        if ({rd_tf_active, wr_tf_active, cmd_inhibit_dat} !== 3'b011 || blocks_left !== BCW'(nblk)) begin
            errors++;
            $display("FAIL wr_load: got psr %b left %0d expected 011 %0d",
                     {rd_tf_active, wr_tf_active, cmd_inhibit_dat}, blocks_left, nblk);
        end
        exp_next = n + 3;
        exp_left = nblk;
        for (int b = 0; b < nblk; b++) begin
            wait_start(60, ok);
            checks++;
            if (!ok || cyc != exp_next) begin
                errors++;
                $display("FAIL wr_start_time: got start %b at %0d expected at %0d (block %0d)",
                         ok, cyc, exp_next, b);
                return;
            end
            dd = $urandom_range(1, 6);
            bl = fixed ? 10 : $urandom_range(1, 12);
            repeat (dd - 1) tick();
            d = cyc + 1;
            r = d + bl;
            if (fixed) rdy = (b == 0) ? r + 7 : d;
            else       rdy = d + $urandom_range(0, bl + 8);
            sdc_busy_L   = 1'b0;
            tx_buf_empty = (d < rdy);
            pulse_done(1'b0);
            exp_left--;
            exp_next = ((r + 2 > rdy) ? r + 2 : rdy) + 1;
            for (int k = 0; k < 60; k++) begin
                sdc_busy_L   = (cyc + 1 >= r);
                tx_buf_empty = (cyc + 1 < rdy);
                tick();
                if (cyc == r + 1) begin
                    checks++;
                    if (blocks_left !== BCW'(exp_left)) begin
                        errors++;
                        $display("FAIL wr_left_step: got %0d expected %0d", blocks_left, exp_left);
                    end
                end
                if (blk_start || tf_complete) break;
            end
        end
        tx_buf_empty = 1'b0;
        sdc_busy_L   = 1'b1;
        checks++;
        if (tf_complete !== 1'b1 || cyc != r + 2) begin
            errors++;
            $display("FAIL wr_tfc_time: got tfc %b at %0d expected 1 at %0d", tf_complete, cyc, r + 2);
        end
        checks++;
        if ({rd_tf_active, wr_tf_active, cmd_inhibit_dat} !== 3'b000 || blocks_left !== '0) begin
            errors++;
            $display("FAIL wr_end_state: got psr %b left %0d expected 000 0",
                     {rd_tf_active, wr_tf_active, cmd_inhibit_dat}, blocks_left);
        end
        tick();
        checks++;
        if (start_q.size() - s0 != nblk || tfc_q.size() - t0 != 1) begin
            errors++;
            $display("FAIL wr_pulse_counts: got starts %0d tfc %0d expected %0d 1",
                     start_q.size() - s0, tfc_q.size() - t0, nblk);
        end
    endtask

    task automatic test_crc_err();
        int n, d, d2, st, exp, t0, e0;
        bit ok;
        t0 = tfc_q.size();
        e0 = derr_q.size();
        rx_buf_full = 1'b0;
        timeout_val = '0;
        do_start(1'b1, 1'b1, 4, $urandom_range(1, 4095));
        n = cyc;
        wait_start(10, ok);
        checks++;
        if (!ok || cyc != n + 3) begin
            errors++;
            $display("FAIL crc_first_start: got %b at %0d expected 1 at %0d", ok, cyc, n + 3);
        end
        repeat ($urandom_range(0, 4)) tick();
        st = $urandom_range(0, 6);
        d  = cyc + 1;
        rx_buf_full = (st > 0);
        pulse_done(1'b0);
        exp = ((d + 2 > d + st) ? d + 2 : d + st) + 1;
        for (int k = 0; k < 20 && !blk_start; k++) begin
            rx_buf_full = (cyc + 1 < d + st);
            tick();
        end
        rx_buf_full = 1'b0;
        checks++;
        if (blk_start !== 1'b1 || cyc != exp) begin
            errors++;
            $display("FAIL rd_gap_start: got %b at %0d expected 1 at %0d", blk_start, cyc, exp);
        end
        repeat ($urandom_range(0, 4)) tick();
        pulse_done(1'b1);
        d2 = cyc;
        tick();
        checks++;
        if (data_err !== 1'b1 || err_code !== 2'b01) begin
            errors++;
            $display("FAIL crc_err_pulse: got derr %b code %b expected 1 01", data_err, err_code);
        end
        checks++;
        if (blocks_left !== BCW'(3) || {rd_tf_active, wr_tf_active, cmd_inhibit_dat} !== 3'b000) begin
            errors++;
            $display("FAIL crc_state: got left %0d psr %b expected 3 000",
                     blocks_left, {rd_tf_active, wr_tf_active, cmd_inhibit_dat});
        end
        repeat (3) tick();
        checks++;
        if (derr_q.size() - e0 != 1 || tfc_q.size() - t0 != 0 || err_code !== 2'b01) begin
            errors++;
            $display("FAIL crc_after: got derr %0d tfc %0d code %b expected 1 0 01 (err at %0d)",
                     derr_q.size() - e0, tfc_q.size() - t0, err_code, d2 + 1);
        end
    endtask

    task automatic test_timeout(input int tv, input bit in_busy);
        int n, s, t0;
        bit ok;
        t0 = tfc_q.size();
        timeout_val = TW'(tv);
        rx_buf_full = 1'b0;
        tx_buf_empty = 1'b0;
        do_start(!in_busy, 1'b0, 1, $urandom_range(1, 4095));
        n = cyc;
        tick();
        checks++;
        if (err_code !== 2'b00) begin
            errors++;
            $display("FAIL err_clear_on_load: got %b expected 00", err_code);
        end
        wait_start(10, ok);
        s = cyc;
        if (in_busy) begin
            repeat (2) tick();
            sdc_busy_L = 1'b0;
            pulse_done(1'b0);
        end
        while (!data_err && cyc < s + tv + 5) tick();
        checks++;
        if (data_err !== 1'b1 || cyc != s + tv) begin
            errors++;
            $display("FAIL tmo_time: got derr %b at +%0d expected 1 at +%0d (busy %0d)",
                     data_err, cyc - s, tv, in_busy);
        end
        checks++;
        if (err_code !== 2'b10 || tfc_q.size() - t0 != 0 || cmd_inhibit_dat !== 1'b0) begin
            errors++;
            $display("FAIL tmo_state: got code %b tfc %0d inhibit %b expected 10 0 0",
                     err_code, tfc_q.size() - t0, cmd_inhibit_dat);
        end
        sdc_busy_L  = 1'b1;
        timeout_val = '0;
        tick();
    endtask

    task automatic test_no_timeout();
        int e0;
        bit ok;
        e0 = derr_q.size();
        timeout_val = '0;
        do_start(1'b1, 1'b0, 1, $urandom_range(1, 4095));
        wait_start(10, ok);
        repeat (150) tick();
        checks++;
        if (derr_q.size() - e0 != 0 || rd_tf_active !== 1'b1) begin
            errors++;
            $display("FAIL no_tmo_wait: got derr %0d rd_active %b expected 0 1", derr_q.size() - e0, rd_tf_active);
        end
        pulse_done(1'b0);
        tick();
        tick();
        checks++;
        if (tf_complete !== 1'b1) begin
            errors++;
            $display("FAIL no_tmo_complete: got %b expected 1", tf_complete);
        end
        tick();
    endtask

    task automatic test_abort();
        int nblk, s0, t0, e0;
        bit ok;
        s0 = start_q.size();
        t0 = tfc_q.size();
        e0 = derr_q.size();
        nblk = $urandom_range(3, 6);
        rx_buf_full = 1'b0;
        do_start(1'b1, 1'b1, nblk, $urandom_range(1, 4095));
        wait_start(10, ok);
        repeat (2) tick();
        pulse_done(1'b0);
        tf_direction = 1'b0;
        multiple_blk = 1'b1;
        block_cnt    = BCW'(7);
        start_tf     = 1'b1;
        tick();
        start_tf     = 1'b0;
        wait_start(10, ok);
        checks++;
        if (!ok || blk_dir !== 1'b1 || blocks_left !== BCW'(nblk - 1)) begin
            errors++;
            $display("FAIL stray_start_ignored: got start %b dir %b left %0d expected 1 1 %0d",
                     ok, blk_dir, blocks_left, nblk - 1);
        end
        repeat ($urandom_range(1, 4)) tick();
        abort    = 1'b1;
        blk_done = 1'b1;
        tick();
        abort    = 1'b0;
        blk_done = 1'b0;
        checks++;
        if ({rd_tf_active, wr_tf_active, cmd_inhibit_dat} !== 3'b000) begin
            errors++;
            $display("FAIL abort_psr: got %b expected 000", {rd_tf_active, wr_tf_active, cmd_inhibit_dat});
        end
        checks++;
        if (blocks_left !== BCW'(nblk - 1)) begin
            errors++;
            $display("FAIL abort_left: got %0d expected %0d", blocks_left, nblk - 1);
        end
        repeat (10) tick();
        checks++;
        if (tfc_q.size() - t0 != 0 || derr_q.size() - e0 != 0 || start_q.size() - s0 != 2) begin
            errors++;
            $display("FAIL abort_no_pulse: got tfc %0d derr %0d starts %0d expected 0 0 2",
                     tfc_q.size() - t0, derr_q.size() - e0, start_q.size() - s0);
        end
        abort = 1'b1;
        repeat (3) tick();
        abort = 1'b0;
        checks++;
        if (blocks_left !== BCW'(nblk - 1) || cmd_inhibit_dat !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_hold: got left %0d inhibit %b expected %0d 0",
                     blocks_left, cmd_inhibit_dat, nblk - 1);
        end
    endtask

    task automatic test_zero_cnt();
        int s0;
        s0 = start_q.size();
        do_start(1'b0, 1'b1, 0, $urandom_range(1, 4095));
        tick();
        checks++;
        if ({wr_tf_active, cmd_inhibit_dat} !== 2'b11) begin
            errors++;
            $display("FAIL zero_psr: got %b expected 11", {wr_tf_active, cmd_inhibit_dat});
        end
        tick();
        checks++;
        if (tf_complete !== 1'b1 || cmd_inhibit_dat !== 1'b0 || blocks_left !== '0) begin
            errors++;
            $display("FAIL zero_complete: got tfc %b inhibit %b left %0d expected 1 0 0",
                     tf_complete, cmd_inhibit_dat, blocks_left);
        end
        repeat (3) tick();
        checks++;
        if (start_q.size() - s0 != 0) begin
            errors++;
            $display("FAIL zero_no_start: got %0d starts expected 0", start_q.size() - s0);
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        do_start(1'b1, 1'b0, 1, $urandom_range(1, 4095));
        wait_start(10, ok);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({blk_start, blk_dir, blk_len, blocks_left, wr_tf_active, rd_tf_active,
             cmd_inhibit_dat, tf_complete, data_err, err_code} !== '0) begin
            errors++;
            $display("FAIL rst_mid: got dir %b len %0d left %0d psr %b code %b expected all 0",
                     blk_dir, blk_len, blocks_left, {rd_tf_active, wr_tf_active, cmd_inhibit_dat}, err_code);
        end
        repeat (5) tick();
        checks++;
        if (blk_start !== 1'b0 || cmd_inhibit_dat !== 1'b0) begin
            errors++;
            $display("FAIL rst_stays_idle: got start %b inhibit %b expected 0 0", blk_start, cmd_inhibit_dat);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_multi_write(3, 1'b1);
        for (int i = 0; i < 4; i++) test_multi_write($urandom_range(1, 5), 1'b0);
        test_crc_err();
        test_timeout(20, 1'b0);
        test_timeout($urandom_range(2, 40), 1'b0);
        test_timeout(30, 1'b1);
        test_no_timeout();
        test_abort();
        test_zero_cnt();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dat_xfer_sched.md
Name: dat_xfer_sched

Overview:
Transfer sequencer for the DAT datapath. It sits between the host register block and the DAT control/phys pair. On a start request it splits a data transfer into single-block operations and issues one block at a time. Before each block it checks TX/RX buffer readiness, waits for block completion and card busy release, and maintains the block countdown, the PSR activity bits, the transfer-complete interrupt and error reporting.

Parameters:
BLOCK_SZ_WIDTH, 12, width of block size field
BLOCK_CNT_WIDTH, 16, width of block count field
TIMEOUT_WIDTH, 16, width of per-block timeout counter

Ports:
host_clk  in  1  single clock for the whole block
rst  in  1  synchronous reset, active-high
start_tf  in  1  one-cycle pulse: begin a data transfer (the command response has been received)
tf_direction  in  1  0 = write (host to card), 1 = read; sampled on start_tf
multiple_blk  in  1  1 = multi-block transfer; sampled on start_tf
block_cnt  in  BLOCK_CNT_WIDTH  number of blocks; sampled on start_tf
block_sz  in  BLOCK_SZ_WIDTH  bytes per block; sampled on start_tf
timeout_val  in  TIMEOUT_WIDTH  per-block timeout in host_clk cycles; 0 disables the timeout
abort  in  1  level; cancels the transfer in progress
tx_buf_empty  in  1  TX FIFO empty flag
rx_buf_full  in  1  RX FIFO full flag
blk_done  in  1  one-cycle pulse from DAT: block plus CRC finished
blk_crc_err  in  1  qualifies blk_done: CRC failed
sdc_busy_L  in  1  card busy, low while busy (write programming)
blk_start  out  1  one-cycle pulse: start one block
blk_dir  out  1  latched direction
blk_len  out  BLOCK_SZ_WIDTH  latched block size
blocks_left  out  BLOCK_CNT_WIDTH  remaining blocks
wr_tf_active  out  1  PSR write-transfer-active bit
rd_tf_active  out  1  PSR read-transfer-active bit
cmd_inhibit_dat  out  1  PSR command-inhibit (DAT) bit
tf_complete  out  1  one-cycle NISR transfer-complete pulse
data_err  out  1  one-cycle error pulse
err_code  out  2  01 = CRC error, 10 = timeout; holds until the next start_tf

Behaviour:
- Reset: state IDLE. All outputs 0; blocks_left = 0; err_code = 00.
- States: IDLE, LOAD, WAIT_BUF, ISSUE, XFER, BUSY_WAIT, NEXT, DONE, ERROR. All outputs are registered.
- IDLE: start_tf moves to LOAD. start_tf in any other state is ignored.
- LOAD (1 cycle):
  - Latch blk_dir and blk_len; clear err_code.
  - blocks_left = block_cnt if multiple_blk = 1, else 1.
  - Set cmd_inhibit_dat and the active bit for the direction (rd if dir = 1, else wr).
  - Multi-block with block_cnt = 0 goes to DONE and issues no blocks. Otherwise goes to WAIT_BUF.
- WAIT_BUF:
  - Write: stay while tx_buf_empty = 1.
  - Read: stay while rx_buf_full = 1.
  - Otherwise go to ISSUE.
  - No timeout applies in this state.
- ISSUE (1 cycle): blk_start = 1; clear the timeout counter; go to XFER.
- XFER:
  - Timeout counter increments every cycle.
  - blk_done with blk_crc_err = 1 goes to ERROR, err_code = 01.
  - blk_done, write direction, goes to BUSY_WAIT.
  - blk_done, read direction, goes to NEXT.
  - If timeout_val != 0 and the counter reaches timeout_val - 1 without blk_done: go to ERROR, err_code = 10.
  - blk_done and timeout in the same cycle: blk_done wins.
- BUSY_WAIT: wait for sdc_busy_L = 1, then go to NEXT. The counter keeps running from XFER and the same timeout rule applies.
- NEXT (1 cycle): blocks_left decrements; next state is DONE if the new value is 0, else WAIT_BUF. blocks_left never wraps below 0.
- DONE (1 cycle): tf_complete = 1; clear wr_tf_active, rd_tf_active and cmd_inhibit_dat; go to IDLE.
- ERROR (1 cycle): data_err = 1; clear the three PSR bits; go to IDLE; tf_complete is not asserted.
- abort = 1 in any non-IDLE state:
  - Next state is IDLE and the three PSR bits clear.
  - No tf_complete or data_err pulse.
  - blocks_left holds its value.
  - abort beats blk_done in the same cycle.
  - abort in IDLE has no effect.
- rst has the highest priority and takes effect mid-transfer.
- Latency: start_tf sampled at cycle N gives the PSR bits at N+1. The earliest blk_start is N+3, when the buffer is ready at N+2. Between blocks, the earliest next blk_start comes 3 cycles after blk_done for reads, and 3 cycles after sdc_busy_L rises for writes.

Test Plan:
- Single-block read: multiple_blk = 0, dir = 1, rx not full; start at cycle 0 -> rd_tf_active = 1 at cycle 1, blk_start at cycle 3; after blk_done -> blocks_left = 0, one tf_complete pulse, all PSR bits = 0.
- Three-block write with busy: block_cnt = 3, dir = 0; tx_buf_empty high for 5 cycles before block 2; sdc_busy_L low 10 cycles after each blk_done -> exactly 3 blk_start pulses, none while tx empty or card busy; blocks_left steps 3 -> 2 -> 1 -> 0; one tf_complete.
- CRC error on block 2 of 4 -> data_err pulse, err_code = 01, blocks_left = 3, no tf_complete, PSR bits cleared.
- Timeout: timeout_val = 20, blk_done never arrives -> data_err exactly 20 cycles after blk_start, err_code = 10; with timeout_val = 0 it waits indefinitely.
- Abort in XFER coinciding with blk_done -> IDLE next cycle, no pulses, blocks_left unchanged; a start_tf sent during the transfer is ignored.
- Edge cases: multiple_blk = 1 with block_cnt = 0 -> tf_complete at cycle 2, no blk_start. rst asserted mid-XFER -> all outputs 0 on the next cycle.
